// File: rtl/result_uart_framer.sv
// result_uart_framer
//   Pops one entry from the result FIFO and sends it to the UART TX byte
//   interface as one frame:
//     SYNC, payload bytes MSB first, then the XOR of the payload bytes.
//
//   Ports
//     clk, reset        clock; asynchronous active-high reset
//     enable            allows a new frame to start (sampled in IDLE only)
//     fifo_empty        FIFO empty flag
//     fifo_data         FIFO read data, valid the cycle after fifo_read
//     fifo_read         one-cycle pop strobe (high only in POP)
//     tx_data/tx_valid  byte to the UART and its valid flag
//     tx_ready          the UART takes the byte on this edge
//     busy              high in every state except IDLE
//     frame_count       number of completed frames, wraps at 16 bits
//
//   WIDTH must be a multiple of 8.
module result_uart_framer #(
    parameter int          WIDTH = 56,
    parameter logic [7:0]  SYNC  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [15:0]      frame_count
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SEND_SYNC,
        SEND_DATA,
        SEND_SUM
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic [7:0]       r_csum;
    logic [IW-1:0]    r_idx;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;
    logic [15:0]      r_frame_count;
    logic             w_xfer;
    logic             w_last;

    assign w_xfer    = r_tx_valid & tx_ready;
    assign w_last    = (r_idx == IW'(NBYTES - 1));
    // Byte that follows the current one: the top byte after the shift.
    assign w_shifted = r_shreg << 8;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (enable && !fifo_empty) w_next = POP;
            POP:       w_next = LOAD;
            LOAD:      w_next = SEND_SYNC;
            SEND_SYNC: if (w_xfer) w_next = SEND_DATA;
            SEND_DATA: if (w_xfer && w_last) w_next = SEND_SUM;
            SEND_SUM:  if (w_xfer) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Datapath: shift register, checksum and the registered TX byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg       <= '0;
            r_csum        <= '0;
            r_idx         <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_shreg    <= fifo_data;
                    r_csum     <= '0;
                    r_idx      <= '0;
                    r_tx_data  <= SYNC;
                    r_tx_valid <= 1'b1;
                end
                SEND_SYNC: begin
                    if (w_xfer) r_tx_data <= r_shreg[WIDTH-1 -: 8];
                end
                SEND_DATA: begin
                    if (w_xfer) begin
                        r_csum  <= r_csum ^ r_tx_data;
                        r_idx   <= r_idx + IW'(1);
                        r_shreg <= w_shifted;
                        // Checksum byte folds in the byte just sent.
                        if (w_last) r_tx_data <= r_csum ^ r_tx_data;
                        else        r_tx_data <= w_shifted[WIDTH-1 -: 8];
                    end
                end
                SEND_SUM: begin
                    if (w_xfer) begin
                        r_tx_valid    <= 1'b0;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // fifo_read and busy are pure state decodes.
    assign fifo_read   = (r_state == POP);
    assign busy        = (r_state != IDLE);
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_result_uart_framer.sv
module tb_result_uart_framer;

    logic        clk = 1'b0;
    logic        reset, enable, fifo_empty, fifo_read, tx_valid, tx_ready, busy;
    logic [55:0] fifo_data;
    logic [7:0]  tx_data;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    localparam logic [55:0] E0 = 56'hDEADBEEF000001;
    localparam logic [55:0] E1 = 56'h0123456789ABCD;
    localparam logic [55:0] E2 = 56'hFFFFFFFFFFFFFF;
    localparam logic [55:0] E3 = 56'h00000000000000;

    always #5 clk = ~clk;

    result_uart_framer #(.WIDTH(56), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_count(frame_count)
    );

    // FIFO model: data valid the cycle after the pop strobe.
    logic [55:0] mem [0:63];
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int pop_err = 0;
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_read) begin
            if (wr_cnt == rd_cnt) pop_err++;
            else begin
                fifo_data <= mem[rd_cnt];
                rd_cnt++;
            end
        end
    end

    // Byte monitor: every transfer with its edge number.
    logic [7:0] got_b [0:1023];
    int         got_c [0:1023];
    int nb  = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc++;
        if (tx_valid && tx_ready && !reset) begin
            got_b[nb] = tx_data;
            got_c[nb] = cyc;
            nb++;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [55:0] e, input int k);
        logic [7:0] s;
        if (k == 0) return 8'hA5;
        if (k <= 7) return e[55 - 8*(k-1) -: 8];
        s = 8'h00;
        for (int j = 0; j < 7; j++) s = s ^ e[55 - 8*j -: 8];
        return s;
    endfunction

    task automatic push(input logic [55:0] e);
        mem[wr_cnt] = e;
        wr_cnt++;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (nb >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (fifo_read !== 1'b0)  begin bad++; $display("FAIL rst_fifo_read got=%b exp=0", fifo_read); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rst_frame_count got=%h exp=0000", frame_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [7:0] exp [0:8];
        int base, rd0, pc;
        bit ok;
        exp = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h23};
        base = nb; rd0 = rd_cnt;
        tx_ready = 1'b1; enable = 1'b1;
        pc = cyc;
        push(E0);
        wait_bytes(base + 9, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d exp=%0d bytes", nb - base, 9); end
        total++; if (got_c[base] !== pc + 4) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", got_c[base] - pc, 4); end
        for (int i = 0; i < 9; i++) begin
            total++; if (got_b[base+i] !== exp[i]) begin bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, got_b[base+i], exp[i]); end
        end
        total++; if (got_c[base+8] - got_c[base] !== 8) begin bad++; $display("FAIL single_consecutive got=%0d exp=8", got_c[base+8] - got_c[base]); end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", rd_cnt - rd0); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL single_count got=%h exp=0001", frame_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
    endtask

    task automatic test_ready_toggle;
        int base, fc0, i;
        logic pv, pr;
        logic [7:0] pd;
        base = nb; fc0 = frame_count;
        enable = 1'b1;
        push(E0);
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        i = 0;
        while (i < 200 && !(nb >= base + 9 && !tx_valid)) begin
            @(negedge clk);
            if (pv && !pr) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== pd) begin
                    bad++; $display("FAIL toggle_hold got=%b/%h exp=1/%h", tx_valid, tx_data, pd);
                end
            end
            tx_ready = (i % 2 == 0);
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            i++;
        end
        enable = 1'b0;
        total++; if (nb - base !== 9) begin bad++; $display("FAIL toggle_count got=%0d exp=9", nb - base); end
        for (int k = 0; k < 9; k++) begin
            total++; if (got_b[base+k] !== exp_byte(E0, k)) begin bad++; $display("FAIL toggle_byte%0d got=%h exp=%h", k, got_b[base+k], exp_byte(E0, k)); end
        end
        total++; if (frame_count !== 16'(fc0 + 1)) begin bad++; $display("FAIL toggle_frames got=%h exp=%h", frame_count, 16'(fc0 + 1)); end
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_three;
        logic [55:0] e [0:2];
        int base, rd0, fc0;
        bit ok;
        e = '{E1, E2, E3};
        base = nb; rd0 = rd_cnt; fc0 = frame_count;
        tx_ready = 1'b1;
        push(E1); push(E2); push(E3);
        enable = 1'b1;
        wait_bytes(base + 27, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL three_timeout got=%0d exp=27", nb - base); end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 9; k++) begin
                total++; if (got_b[base+9*f+k] !== exp_byte(e[f], k)) begin bad++; $display("FAIL three_f%0d_b%0d got=%h exp=%h", f, k, got_b[base+9*f+k], exp_byte(e[f], k)); end
            end
            total++; if (got_c[base+9*f+8] - got_c[base+9*f] !== 8) begin bad++; $display("FAIL three_consec%0d got=%0d exp=8", f, got_c[base+9*f+8] - got_c[base+9*f]); end
        end
        total++; if (got_c[base+9] - got_c[base+8] !== 4) begin bad++; $display("FAIL three_gap1 got=%0d exp=4", got_c[base+9] - got_c[base+8]); end
        total++; if (got_c[base+18] - got_c[base+17] !== 4) begin bad++; $display("FAIL three_gap2 got=%0d exp=4", got_c[base+18] - got_c[base+17]); end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rd_cnt - rd0 !== 3) begin bad++; $display("FAIL three_pops got=%0d exp=3", rd_cnt - rd0); end
        total++; if (frame_count !== 16'(fc0 + 3)) begin bad++; $display("FAIL three_frames got=%h exp=%h", frame_count, 16'(fc0 + 3)); end
    endtask

    task automatic test_enable_low;
        int viol, rd0;
        viol = 0; rd0 = rd_cnt;
        enable = 1'b0;
        push(E1); push(E2);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_read !== 1'b0 || busy !== 1'b0) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL enlow_activity got=%0d exp=0 cycles", viol); end
        total++; if (rd_cnt !== rd0) begin bad++; $display("FAIL enlow_pops got=%0d exp=0", rd_cnt - rd0); end
    endtask

    task automatic test_enable_drop;
        int base, rd0, busy_seen;
        bit ok;
        base = nb; rd0 = rd_cnt; busy_seen = 0;
        enable = 1'b1;
        wait_bytes(base + 3, 50, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL endrop_start got=%0d exp=3", nb - base); end
        wait_bytes(base + 9, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL endrop_complete got=%0d exp=9", nb - base); end
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy || fifo_read) busy_seen++;
        end
        for (int k = 0; k < 9; k++) begin
            total++; if (got_b[base+k] !== exp_byte(E1, k)) begin bad++; $display("FAIL endrop_byte%0d got=%h exp=%h", k, got_b[base+k], exp_byte(E1, k)); end
        end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL endrop_restart got=%0d exp=0", busy_seen); end
        total++; if (rd_cnt - rd0 !== 1) begin bad++; $display("FAIL endrop_pops got=%0d exp=1", rd_cnt - rd0); end
        total++; if (nb - base !== 9) begin bad++; $display("FAIL endrop_bytes got=%0d exp=9", nb - base); end
    endtask

    task automatic test_reset_mid;
        int base, base2;
        bit ok;
        base = nb;
        tx_ready = 1'b1; enable = 1'b1;
        wait_bytes(base + 4, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_start got=%0d exp=4", nb - base); end
        #2 reset = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0)  begin bad++; $display("FAIL rmid_tx_valid got=%b exp=0", tx_valid); end
        total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL rmid_fifo_read got=%b exp=0", fifo_read); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL rmid_count got=%h exp=0000", frame_count); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        push(E3);
        @(negedge clk);
        reset = 1'b0;
        base2 = nb;
        wait_bytes(base2 + 9, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=%0d exp=9", nb - base2); end
        for (int k = 0; k < 9; k++) begin
            total++; if (got_b[base2+k] !== exp_byte(E3, k)) begin bad++; $display("FAIL rmid_byte%0d got=%h exp=%h", k, got_b[base2+k], exp_byte(E3, k)); end
        end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL rmid_frames got=%h exp=0001", frame_count); end
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap;
        int base;
        bit ok;
        enable = 1'b0;
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_frame_count;
        @(negedge clk);
        total++; if (frame_count !== 16'hFFFE) begin bad++; $display("FAIL wrap_preset got=%h exp=fffe", frame_count); end
        base = nb;
        push(E0); push(E2);
        tx_ready = 1'b1; enable = 1'b1;
        wait_bytes(base + 9, 50, ok);
        total++; if (!ok || frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", frame_count); end
        wait_bytes(base + 18, 50, ok);
        total++; if (!ok || frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", frame_count); end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pop_err !== 0) begin bad++; $display("FAIL pop_while_empty got=%0d exp=0", pop_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ready_toggle();
        test_three();
        test_enable_low();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
